// File: rtl/lopd_normalizer_seq.sv
// rtl/lopd_normalizer_seq.sv - iterative mantissa normalizer driven by a leading-one position
// Optional position consistency check: define LOPD_NORM_POS_CHECK_EN.
module lopd_normalizer_seq #(
  parameter int SIZE_DATA  = 24,
  parameter int SIZE_LOPD  = 5,
  parameter int SIZE_EXP   = 8,
  parameter int SHIFT_STEP = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic [SIZE_LOPD-1:0] i_one_position,
  input  logic                 i_zero_flag,
  input  logic [SIZE_EXP-1:0]  i_exp,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_mantissa,
  output logic [SIZE_EXP-1:0]  o_exp,
  output logic                 o_zero,
  output logic                 o_underflow,
  output logic                 o_pos_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int EW = (SIZE_EXP > SIZE_LOPD) ? SIZE_EXP : SIZE_LOPD;
  localparam logic [SIZE_LOPD-1:0] TOP_POS = SIZE_LOPD'(SIZE_DATA - 1);
  localparam logic [SIZE_LOPD-1:0] STEP    = SIZE_LOPD'(SHIFT_STEP);

  state_t               r_state;
  state_t               w_next;
  logic                 r_ready;
  logic [SIZE_DATA-1:0] r_mant;
  logic [SIZE_EXP-1:0]  r_exp;
  logic [SIZE_LOPD-1:0] r_rem;
  logic                 r_zero;
  logic                 r_underflow;
  logic                 r_pos_err;

  logic                 w_accept;
  logic [SIZE_LOPD-1:0] w_pos_eff;
  logic                 w_pos_err;
  logic [SIZE_LOPD-1:0] w_shift;
  logic [SIZE_LOPD-1:0] w_step;
  logic [SIZE_LOPD-1:0] w_rem_next;
  logic                 w_exp_ok;

  assign w_accept = r_ready & i_valid;

`ifdef LOPD_NORM_POS_CHECK_EN
  logic w_pos_over;
  assign w_pos_over = (i_one_position > TOP_POS);
  // Out-of-range positions clamp to "already normalized"; mismatched ones are still honoured.
  assign w_pos_eff  = w_pos_over ? TOP_POS : i_one_position;
  assign w_pos_err  = !i_zero_flag &&
                      (w_pos_over || ((i_data >> i_one_position) != SIZE_DATA'(1)));
`else
  assign w_pos_eff  = i_one_position;
  assign w_pos_err  = 1'b0;
`endif

  assign w_shift    = TOP_POS - w_pos_eff;
  assign w_step     = (r_rem > STEP) ? STEP : r_rem;
  assign w_rem_next = r_rem - w_step;
  assign w_exp_ok   = (EW'(i_exp) > EW'(w_shift));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (i_zero_flag || (w_shift == '0)) w_next = DONE;
          else                                w_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_rem_next == '0) w_next = DONE;
      end
      DONE: begin
        if (i_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mant      <= '0;
      r_exp       <= '0;
      r_rem       <= '0;
      r_zero      <= 1'b0;
      r_underflow <= 1'b0;
      r_pos_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pos_err <= w_pos_err;
            if (i_zero_flag) begin
              r_mant      <= '0;
              r_exp       <= '0;
              r_rem       <= '0;
              r_zero      <= 1'b1;
              r_underflow <= 1'b0;
            end else begin
              r_mant <= i_data;
              r_rem  <= w_shift;
              r_zero <= 1'b0;
              // Exponent is settled up front; the mantissa is normalized even on underflow.
              if (w_exp_ok) begin
                r_exp       <= i_exp - SIZE_EXP'(w_shift);
                r_underflow <= 1'b0;
              end else begin
                r_exp       <= '0;
                r_underflow <= 1'b1;
              end
            end
          end
        end
        SHIFT: begin
          r_mant <= r_mant << w_step;
          r_rem  <= w_rem_next;
        end
        DONE: begin
          if (i_ready) r_pos_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_valid     = (r_state == DONE);
  assign o_mantissa  = r_mant;
  assign o_exp       = r_exp;
  assign o_zero      = r_zero;
  assign o_underflow = r_underflow;
  assign o_pos_err   = r_pos_err;

endmodule

// File: tb/tb_lopd_normalizer_seq.sv
// tb/tb_lopd_normalizer_seq.sv - scoreboard bench for lopd_normalizer_seq
module tb_lopd_normalizer_seq;

  localparam int SD = 24;
  localparam int SL = 5;
  localparam int SE = 8;
  localparam int ST = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [SD-1:0] data = '0;
  logic [SL-1:0] pos = '0;
  logic          zf = 1'b0;
  logic [SE-1:0] expo = '0;
  logic          o_ready, o_valid, o_zero, o_underflow, o_pos_err;
  logic [SD-1:0] o_mantissa;
  logic [SE-1:0] o_exp;

  lopd_normalizer_seq #(.SIZE_DATA(SD), .SIZE_LOPD(SL), .SIZE_EXP(SE), .SHIFT_STEP(ST)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(data), .i_one_position(pos), .i_zero_flag(zf), .i_exp(expo),
    .o_valid(o_valid), .i_ready(i_ready), .o_mantissa(o_mantissa), .o_exp(o_exp),
    .o_zero(o_zero), .o_underflow(o_underflow), .o_pos_err(o_pos_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SD-1:0] m;
    logic [SE-1:0] e;
    logic          z;
    logic          uf;
    logic          pe;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference: the leading one must end up at the top bit; shift amount is the distance to it.
  function automatic exp_t model(input logic [SD-1:0] d, input int p, input logic z, input int e);
    exp_t r;
    int   s;
    r.pe  = 1'b0;
    r.acc = 0;
    if (z) begin
      r.m = '0; r.e = '0; r.z = 1'b1; r.uf = 1'b0; r.lat = 1;
      return r;
    end
`ifdef LOPD_NORM_POS_CHECK_EN
    if (p > SD - 1) begin
      r.pe = 1'b1;
      p    = SD - 1;
    end else if ((int'(d) / (2 ** p)) != 1) begin
      r.pe = 1'b1;
    end
`endif
    s    = (SD - 1) - p;
    r.m  = SD'((longint'(d) * longint'(2 ** s)) % (longint'(1) << SD));
    r.z  = 1'b0;
    if (e > s) begin
      r.e  = SE'(e - s);
      r.uf = 1'b0;
    end else begin
      r.e  = '0;
      r.uf = 1'b1;
    end
    r.lat = (s == 0) ? 1 : 1 + (s + ST - 1) / ST;
    return r;
  endfunction

  task automatic issue(input logic [SD-1:0] d, input int p, input logic z, input int e);
    int   n;
    exp_t r;
    @(negedge clk);
    data = d; pos = SL'(p); zf = z; expo = SE'(e); i_valid = 1'b1;
    n = 0;
    while (o_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail_now("accept_wait");
    end else begin
      r     = model(d, p, z, e);
      r.acc = cyc;
      sb.push_back(r);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || o_ready !== 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now(name);
  endtask

  // Monitor: pops on the first cycle of each result, then checks it holds until taken.
  initial begin
    logic          seen;
    int            hold;
    exp_t          cur;
    logic [SD-1:0] hm;
    logic [SE-1:0] he;
    logic [3:0]    hf;
    seen = 1'b0;
    hold = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        seen = 1'b0;
        i_ready = 1'b0;
      end else if (o_valid === 1'b1) begin
        chk("ready_low_in_done", {31'b0, o_ready}, 32'd0);
        if (!seen) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=valid required=none");
          end else begin
            cur = sb.pop_front();
            chk("mantissa", {8'b0, o_mantissa}, {8'b0, cur.m});
            chk("exp", {24'b0, o_exp}, {24'b0, cur.e});
            chk("flags", {28'b0, o_zero, o_underflow, o_pos_err, 1'b0},
                {28'b0, cur.z, cur.uf, cur.pe, 1'b0});
            chk("latency", cyc - cur.acc, cur.lat);
            n_done++;
          end
          seen = 1'b1;
          hm   = o_mantissa;
          he   = o_exp;
          hf   = {o_zero, o_underflow, o_pos_err, 1'b0};
          hold = (n_done == 1) ? 5 : int'($urandom_range(0, 3));
        end else begin
          chk("hold_stable", {o_mantissa, o_exp}, {hm, he});
          chk("hold_flags", {28'b0, o_zero, o_underflow, o_pos_err, 1'b0}, {28'b0, hf});
        end
        if (hold > 0) begin
          i_ready = 1'b0;
          hold--;
        end else begin
          i_ready = 1'b1;
        end
        if (i_ready) seen = 1'b0;
      end else begin
        seen    = 1'b0;
        i_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    int          p;
    int          n;
    logic [SD-1:0] d;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, o_ready}, 32'd0);
    chk("rst_outputs", {o_valid, o_zero, o_underflow, o_pos_err, o_mantissa, o_exp}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, o_ready}, 32'd1);
    chk("post_rst_outputs", {o_valid, o_zero, o_underflow, o_pos_err, o_mantissa, o_exp}, 32'd0);

    issue(24'h000001, 0, 1'b0, 100);
    issue(24'h800000, 23, 1'b0, 5);
    issue(24'h000000, 7, 1'b1, 55);
    issue(24'h000100, 8, 1'b0, 10);
    issue(24'h000001, 0, 1'b0, 23);
`ifdef LOPD_NORM_POS_CHECK_EN
    issue(24'h800000, 25, 1'b0, 50);
    issue(24'h000010, 3, 1'b0, 50);
`endif
    @(negedge clk);
    i_valid = 1'b0;
    wait_idle("drain_directed");

    // Abort an operation mid-shift with reset; nothing may come out of it.
    @(negedge clk);
    data = 24'h000001; pos = '0; zf = 1'b0; expo = 8'd100; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    chk("abort_in_shift", {30'b0, o_valid, o_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rst_outputs", {o_valid, o_ready, o_mantissa, o_exp}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_valid !== 1'b0) n++;
    end
    chk("abort_no_valid", n, 0);
    chk("abort_idle", {31'b0, o_ready}, 32'd1);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        issue('0, int'($urandom_range(0, SD - 1)), 1'b1, int'($urandom_range(0, 255)));
      end else begin
        p = int'($urandom_range(0, SD - 1));
        d = SD'((longint'(1) << p) | (longint'($urandom) % (longint'(1) << p)));
        issue(d, p, 1'b0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30))
                                                    : int'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        i_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    wait_idle("drain_random");
    chk("all_results_seen", n_done, 303 + 0
`ifdef LOPD_NORM_POS_CHECK_EN
        + 2
`endif
        + 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
